mux_arb_nto1: RTL and testbench
===============================

Name: mux_arb_nto1

Overview:
Parametrised N-channel to 1 registered multiplexer with built-in arbitration and valid/ready handshake. It generalises the datapath 2-to-1 select to CH requesters, selectable fixed-priority or round-robin grant, and a one-deep output register. It sits between multiple producers, such as writeback or forwarding sources, and a single consumer stage of the CPU datapath.

Parameters:
SIZE, 32, data width per channel in bits
CH, 4, number of input channels (2..16)
SEL_W, 2, width of grant index; must equal ceil(log2(CH))
MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset, asynchronous, active-low
valid_i  input  CH  per-channel request; bit k belongs to channel k
data_i  input  CH*SIZE  packed channel data; channel k occupies bits [k*SIZE+SIZE-1 : k*SIZE]
ready_o  output  CH  per-channel accept, one-hot or zero
valid_o  output  1  output register holds a valid word
data_o  output  SIZE  output register data
grant_o  output  SEL_W  index of the channel whose word is in the output register
ready_i  input  1  consumer accepts the output word

Behaviour:
- Reset (rst_i low, asynchronous): valid_o=0, data_o=0, grant_o=0, RR pointer=0. Any held word is discarded. Outputs are stable from the reset assertion edge, not the next clock.
- load_en = !valid_o || ready_i. The output register is free, or is being drained this cycle.
- Arbitration is combinational over valid_i:
  - MODE=1: winner is the lowest k with valid_i[k]=1.
  - MODE=0: search starts at the pointer p, then p+1 … CH-1, wrapping to 0 … p-1. Winner is the first k found with valid_i[k]=1.
- ready_o[w]=load_en for the winner w. All other bits are 0. If no valid_i bit is set, ready_o=0.
- ready_o depends combinationally on ready_i and valid_i. Producers must not make valid_i depend on ready_o.
- Input transfer occurs on a rising edge when valid_i[w] && ready_o[w]. At that edge:
  - data_o <= data_i slice w
  - grant_o <= w
  - valid_o <= 1
  - MODE=0 only: pointer <= (w+1) mod CH
- Output transfer occurs on an edge with valid_o && ready_i.
  - With no simultaneous input transfer: valid_o <= 0. data_o and grant_o hold their last values.
  - With a simultaneous input transfer: the register reloads. There is no bubble, giving full throughput of one word per cycle.
- Stall: while valid_o=1 and ready_i=0, data_o, grant_o and valid_o hold, and all ready_o bits are 0.
- Pointer changes only on an input transfer. Requests that appear and vanish without transfer leave it unchanged.
- Latency: a word accepted at edge n is visible on data_o after edge n.
- Producer contract: a producer holds valid_i and its data until accepted. The block does not check this.
- Wrap-around: when the winner is CH-1, the pointer returns to 0.
- Single channel requesting continuously: in both modes it is granted every cycle the register is free.
- Width rule: data is passed unmodified, with no extension or truncation. The grant index is zero-extended into SEL_W.

Test Plan:
1. Reset mid-burst: CH=4, valid_o=1, data_o=32'hDEAD_BEEF, rst_i pulsed low between edges -> valid_o=0, data_o=0, grant_o=0 immediately, and the next grant starts from channel 0.
2. Round-robin fairness: MODE=0, valid_i=4'b1111 held, ready_i=1, channel k data=32'h1000_000k -> grant_o sequence 0,1,2,3,0,1 on consecutive cycles, valid_o=1 every cycle after the first, no bubbles.
3. Fixed priority: MODE=1, valid_i=4'b1010, ready_i=1 -> ready_o=4'b0010 every cycle. Channel 3 is never granted while channel 1 requests.
4. Backpressure: one word loaded from channel 2, then ready_i=0 for 3 cycles with valid_i=4'b0101 -> ready_o=0, and data_o/grant_o=2 held for those cycles. On the cycle ready_i=1, ready_o is one-hot and the register reloads on that edge.
5. Sparse round-robin with wrap: MODE=0, pointer=3, valid_i=4'b0011 -> channel 0 granted, pointer becomes 1. Next cycle, channel 1 is granted.
6. Idle drain: single word loaded, then valid_i=0 and ready_i=1 -> valid_o falls after one edge, data_o retains the last value, and the pointer is unchanged.

Source files
------------

// File: rtl/mux_arb_nto1_if.sv
// mux_arb_nto1_if: handshake/bus bundle for the N-to-1 arbitrating mux.
//   valid_i  CH       per-channel request from the producers
//   data_i   CH*SIZE  packed channel data, channel k at [k*SIZE +: SIZE]
//   ready_o  CH       per-channel accept, one-hot or zero
//   valid_o  1        output register holds a valid word
//   data_o   SIZE     output register data
//   grant_o  SEL_W    channel index of the word in the output register
//   ready_i  1        consumer accepts the output word
// The "slave" modport is the mux side; "master" is the producer/consumer side.
interface mux_arb_nto1_if #(
    parameter int SIZE  = 32,
    parameter int CH    = 4,
    parameter int SEL_W = 2
);
    logic [CH-1:0]      valid_i;
    logic [CH*SIZE-1:0] data_i;
    logic [CH-1:0]      ready_o;
    logic               valid_o;
    logic [SIZE-1:0]    data_o;
    logic [SEL_W-1:0]   grant_o;
    logic               ready_i;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, grant_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, grant_o
    );
endinterface

// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: CH-channel to 1 registered multiplexer with arbitration and
// valid/ready handshake on both sides. One-deep output register, full
// throughput when the consumer drains and a producer refills in the same cycle.
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-low reset
//   bus    mux_arb_nto1_if.slave (see interface file for the signal list)
// MODE = 0: round-robin starting at a rotating pointer.
// MODE = 1: fixed priority, lowest channel index wins.
// SEL_W must equal ceil(log2(CH)).
module mux_arb_nto1 #(
    parameter int SIZE  = 32,
    parameter int CH    = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mux_arb_nto1_if.slave      bus
);
    // One extra bit so pointer + offset can exceed CH-1 before the wrap.
    localparam int IW = SEL_W + 1;

    logic              valid_q, valid_d;
    logic [SIZE-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  ptr_q,   ptr_d;

    logic              load_en;
    logic              found;
    logic [SEL_W-1:0]  win;
    logic [IW-1:0]     idx;
    logic [CH-1:0]     ready;
    logic              in_xfer;

    // Register is free, or is being drained on this edge.
    assign load_en = !valid_q || bus.ready_i;

    // Search order: fixed 0..CH-1, or rotated so the pointer is checked first.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < CH; i++) begin
            if (MODE == 1) begin
                idx = IW'(i);
            end else begin
                idx = {1'b0, ptr_q} + IW'(i);
                if (idx >= IW'(CH)) begin
                    idx = idx - IW'(CH);
                end
            end
            if (!found && bus.valid_i[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (found) begin
            ready[win] = load_en;
        end
    end

    assign in_xfer = found && load_en;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            valid_d = 1'b1;
            data_d  = bus.data_i[win*SIZE +: SIZE];
            grant_d = win;
            if (MODE == 0) begin
                ptr_d = (win == SEL_W'(CH - 1)) ? '0 : win + 1'b1;
            end
        end else if (valid_q && bus.ready_i) begin
            // Drain without refill: data and grant keep their last values.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.grant_o = grant_q;
endmodule

// File: tb/tb_mux_arb_nto1.sv
module tb_mux_arb_nto1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_arb_nto1_if #(.SIZE(32), .CH(4), .SEL_W(2)) if_rr ();
    mux_arb_nto1_if #(.SIZE(32), .CH(4), .SEL_W(2)) if_fp ();

    mux_arb_nto1 #(.SIZE(32), .CH(4), .SEL_W(2), .MODE(0)) u_rr (
        .clk_i(clk), .rst_i(rst_n), .bus(if_rr)
    );
    mux_arb_nto1 #(.SIZE(32), .CH(4), .SEL_W(2), .MODE(1)) u_fp (
        .clk_i(clk), .rst_i(rst_n), .bus(if_fp)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [1:0]  exp_grant;
    } vec_t;

    localparam logic [31:0] D0 = 32'h1000_0000;
    localparam logic [31:0] D1 = 32'h1000_0001;
    localparam logic [31:0] D2 = 32'h1000_0002;
    localparam logic [31:0] D3 = 32'h1000_0003;

    vec_t vecs[19];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_default_data();
        for (int k = 0; k < 4; k++) begin
            if_rr.data_i[k*32 +: 32] = 32'h1000_0000 + 32'(k);
            if_fp.data_i[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        end
    endtask

    initial begin
        // Round-robin vectors, applied from reset (pointer 0, register empty).
        // Fairness, sparse wrap, idle drain, pointer-hold, backpressure, drain.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, D3, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
        vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[7]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[8]  = '{4'b0011, 1'b1, 4'b0010, 1'b1, D1, 2'd1};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, D1, 2'd1};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, D1, 2'd1};
        vecs[11] = '{4'b1111, 1'b0, 4'b0100, 1'b1, D2, 2'd2};
        vecs[12] = '{4'b0101, 1'b0, 4'b0000, 1'b1, D2, 2'd2};
        vecs[13] = '{4'b0101, 1'b0, 4'b0000, 1'b1, D2, 2'd2};
        vecs[14] = '{4'b0101, 1'b0, 4'b0000, 1'b1, D2, 2'd2};
        vecs[15] = '{4'b0101, 1'b1, 4'b0001, 1'b1, D0, 2'd0};
        vecs[16] = '{4'b0101, 1'b1, 4'b0100, 1'b1, D2, 2'd2};
        vecs[17] = '{4'b0000, 1'b0, 4'b0000, 1'b1, D2, 2'd2};
        vecs[18] = '{4'b0000, 1'b1, 4'b0000, 1'b0, D2, 2'd2};

        if_rr.valid_i = '0; if_rr.ready_i = 1'b0;
        if_fp.valid_i = '0; if_fp.ready_i = 1'b0;
        load_default_data();

        #2;
        chk("reset valid_o", 64'(if_rr.valid_o), 64'd0);
        chk("reset data_o",  64'(if_rr.data_o),  64'd0);
        chk("reset grant_o", 64'(if_rr.grant_o), 64'd0);
        chk("reset fp valid_o", 64'(if_fp.valid_o), 64'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if_rr.valid_i = vecs[i].valid;
            if_rr.ready_i = vecs[i].rdy;
            #1;
            chk($sformatf("rr[%0d] ready_o", i), 64'(if_rr.ready_o), 64'(vecs[i].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("rr[%0d] valid_o", i), 64'(if_rr.valid_o), 64'(vecs[i].exp_valid));
            chk($sformatf("rr[%0d] data_o", i),  64'(if_rr.data_o),  64'(vecs[i].exp_data));
            chk($sformatf("rr[%0d] grant_o", i), 64'(if_rr.grant_o), 64'(vecs[i].exp_grant));
        end

        // Reset mid-burst: load DEAD_BEEF from channel 1 (pointer now 3 -> 2 after).
        if_rr.data_i[63:32] = 32'hDEAD_BEEF;
        if_rr.valid_i = 4'b0010;
        if_rr.ready_i = 1'b0;
        @(posedge clk); #1;
        chk("rst pre valid_o", 64'(if_rr.valid_o), 64'd1);
        chk("rst pre data_o",  64'(if_rr.data_o),  64'hDEAD_BEEF);
        chk("rst pre grant_o", 64'(if_rr.grant_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst async valid_o", 64'(if_rr.valid_o), 64'd0);
        chk("rst async data_o",  64'(if_rr.data_o),  64'd0);
        chk("rst async grant_o", 64'(if_rr.grant_o), 64'd0);
        #2;
        rst_n = 1'b1;
        load_default_data();
        if_rr.valid_i = 4'b1111;
        if_rr.ready_i = 1'b1;
        #1;
        chk("rst post ready_o", 64'(if_rr.ready_o), 64'b0001);
        @(posedge clk); #1;
        chk("rst post grant_o", 64'(if_rr.grant_o), 64'd0);
        chk("rst post data_o",  64'(if_rr.data_o),  64'(D0));
        if_rr.valid_i = '0;

        // Fixed priority: channel 1 always beats channel 3.
        if_fp.valid_i = 4'b1010;
        if_fp.ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fp[%0d] ready_o", i), 64'(if_fp.ready_o), 64'b0010);
            @(posedge clk); #1;
            chk($sformatf("fp[%0d] grant_o", i), 64'(if_fp.grant_o), 64'd1);
            chk($sformatf("fp[%0d] data_o", i),  64'(if_fp.data_o),  64'(D1));
            chk($sformatf("fp[%0d] valid_o", i), 64'(if_fp.valid_o), 64'd1);
        end
        if_fp.ready_i = 1'b0;
        #1;
        chk("fp stall ready_o", 64'(if_fp.ready_o), 64'd0);
        @(posedge clk); #1;
        chk("fp stall grant_o", 64'(if_fp.grant_o), 64'd1);
        if_fp.valid_i = 4'b1000;
        if_fp.ready_i = 1'b1;
        #1;
        chk("fp ch3 ready_o", 64'(if_fp.ready_o), 64'b1000);
        @(posedge clk); #1;
        chk("fp ch3 grant_o", 64'(if_fp.grant_o), 64'd3);
        chk("fp ch3 data_o",  64'(if_fp.data_o),  64'(D3));
        if_fp.valid_i = 4'b0000;
        @(posedge clk); #1;
        chk("fp drain valid_o", 64'(if_fp.valid_o), 64'd0);
        chk("fp drain data_o",  64'(if_fp.data_o),  64'(D3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
